alu_issue_stage: RTL and testbench

- Issue stage directly upstream of the ALU.
- Accepts decoded instructions from ID over a valid/ready handshake.
- Resolves operands: register read data, PC, immediate, constants, and forwarding from the EX/MEM and MEM/WB stages.
- Drives registered alu_src0/alu_src1/alu_op to the ALU through a 2-entry skid buffer, so back-pressure never creates a combinational ready path upstream.

---
 rtl/alu_issue_stage_pkg.sv | 41 ++++
 rtl/alu_issue_stage_operand_fwd_mux.sv | 32 +++
 rtl/alu_issue_stage.sv | 137 +++++++++++++
 tb/tb_alu_issue_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, operand selects and the
// buffered entry layout.
package alu_issue_stage_pkg;

  localparam int ENTRY_DATA_W = 32;
  localparam int ENTRY_REG_AW = 5;
  localparam int OP_W         = 5;

  localparam logic [OP_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'b00010;
  localparam logic [OP_W-1:0] ALU_SLT  = 5'b00100;
  localparam logic [OP_W-1:0] ALU_SLTU = 5'b00101;
  localparam logic [OP_W-1:0] ALU_AND  = 5'b01001;
  localparam logic [OP_W-1:0] ALU_OR   = 5'b01010;
  localparam logic [OP_W-1:0] ALU_XOR  = 5'b01011;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'b01110;
  localparam logic [OP_W-1:0] ALU_SRL  = 5'b01111;
  localparam logic [OP_W-1:0] ALU_SRA  = 5'b10000;
  localparam logic [OP_W-1:0] ALU_SRC0 = 5'b10001;
  localparam logic [OP_W-1:0] ALU_SRC1 = 5'b10010;

  localparam logic [1:0] SRC0_RS1   = 2'd0;
  localparam logic [1:0] SRC0_PC    = 2'd1;
  localparam logic [1:0] SRC0_ZERO  = 2'd2;
  localparam logic [1:0] SRC0_ZERO3 = 2'd3;

  localparam logic [1:0] SRC1_RS2   = 2'd0;
  localparam logic [1:0] SRC1_IMM   = 2'd1;
  localparam logic [1:0] SRC1_FOUR  = 2'd2;
  localparam logic [1:0] SRC1_ZERO  = 2'd3;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] pc;
    logic [ENTRY_DATA_W-1:0] src0;
    logic [ENTRY_DATA_W-1:0] src1;
    logic [OP_W-1:0]         op;
    logic [ENTRY_REG_AW-1:0] rd;
    logic                    rd_we;
  } entry_t;

endpackage

// File: rtl/alu_issue_stage_operand_fwd_mux.sv
// Resolves one source register against the EX/MEM and MEM/WB forward ports;
// the younger EX/MEM result wins and x0 is never forwarded.
module operand_fwd_mux
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic              exf_we,
  input  logic [REG_AW-1:0] exf_rd,
  input  logic [DATA_W-1:0] exf_data,
  input  logic              wbf_we,
  input  logic [REG_AW-1:0] wbf_rd,
  input  logic [DATA_W-1:0] wbf_data,
  output logic [DATA_W-1:0] fwd_data
);

  logic rs_nonzero;
  assign rs_nonzero = (rs_addr != '0);

  always_comb begin
    fwd_data = rs_data;
    if (rs_nonzero && exf_we && (exf_rd == rs_addr)) begin
      fwd_data = exf_data;
    end else if (rs_nonzero && wbf_we && (wbf_rd == rs_addr)) begin
      fwd_data = wbf_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding the ALU: resolves operands at acceptance and holds them
// in a main register backed by one skid entry so in_ready is register-driven.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W = ENTRY_DATA_W,
  parameter int REG_AW = ENTRY_REG_AW
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [1:0]        in_src0_sel,
  input  logic [1:0]        in_src1_sel,
  input  logic [4:0]        in_alu_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              exf_we,
  input  logic [REG_AW-1:0] exf_rd,
  input  logic [DATA_W-1:0] exf_data,
  input  logic              wbf_we,
  input  logic [REG_AW-1:0] wbf_rd,
  input  logic [DATA_W-1:0] wbf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_src0,
  output logic [DATA_W-1:0] alu_src1,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we
);

  // Entry layout comes from the package, so DATA_W/REG_AW must match its widths.
  logic [DATA_W-1:0] rs1_fwd_p0;
  logic [DATA_W-1:0] rs2_fwd_p0;
  entry_t            entry_p0;
  logic              accept_p0;

  entry_t            main_p1;
  entry_t            skid_p1;
  logic              vld_p1;
  logic              skid_vld_p1;
  logic              drain_p1;

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr  (in_rs1_addr),
    .rs_data  (in_rs1_data),
    .exf_we   (exf_we),
    .exf_rd   (exf_rd),
    .exf_data (exf_data),
    .wbf_we   (wbf_we),
    .wbf_rd   (wbf_rd),
    .wbf_data (wbf_data),
    .fwd_data (rs1_fwd_p0)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr  (in_rs2_addr),
    .rs_data  (in_rs2_data),
    .exf_we   (exf_we),
    .exf_rd   (exf_rd),
    .exf_data (exf_data),
    .wbf_we   (wbf_we),
    .wbf_rd   (wbf_rd),
    .wbf_data (wbf_data),
    .fwd_data (rs2_fwd_p0)
  );

  // Stage p0: operand selection at acceptance time
  always_comb begin
    entry_p0       = '0;
    entry_p0.pc    = in_pc;
    entry_p0.op    = in_alu_op;
    entry_p0.rd    = in_rd;
    entry_p0.rd_we = in_rd_we;
    case (in_src0_sel)
      SRC0_RS1: entry_p0.src0 = rs1_fwd_p0;
      SRC0_PC:  entry_p0.src0 = in_pc;
      default:  entry_p0.src0 = '0;
    endcase
    case (in_src1_sel)
      SRC1_RS2:  entry_p0.src1 = rs2_fwd_p0;
      SRC1_IMM:  entry_p0.src1 = in_imm;
      SRC1_FOUR: entry_p0.src1 = DATA_W'(4);
      default:   entry_p0.src1 = '0;
    endcase
  end

  assign in_ready  = !skid_vld_p1;
  assign accept_p0 = in_valid && in_ready && !flush;
  assign drain_p1  = vld_p1 && out_ready;

  // Stage p1: main register plus skid entry
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (skid_vld_p1) begin
      if (drain_p1) begin
        main_p1     <= skid_p1;
        skid_vld_p1 <= 1'b0;
      end
    end else if (accept_p0) begin
      if (!vld_p1 || drain_p1) begin
        main_p1 <= entry_p0;
        vld_p1  <= 1'b1;
      end else begin
        skid_p1     <= entry_p0;
        skid_vld_p1 <= 1'b1;
      end
    end else if (drain_p1) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign alu_src0  = main_p1.src0;
  assign alu_src1  = main_p1.src1;
  assign alu_op    = main_p1.op;
  assign out_pc    = main_p1.pc;
  assign out_rd    = main_p1.rd;
  assign out_rd_we = main_p1.rd_we;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized bench for alu_issue_stage against a queue-based
// model of the buffered instructions.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd, in_alu_op;
  logic [1:0]  in_src0_sel, in_src1_sel;
  logic        in_rd_we;
  logic        exf_we, wbf_we;
  logic [4:0]  exf_rd, wbf_rd;
  logic [31:0] exf_data, wbf_data;
  logic        out_valid, out_ready;
  logic [31:0] alu_src0, alu_src1, out_pc;
  logic [4:0]  alu_op, out_rd;
  logic        out_rd_we;

  int errors = 0;
  int checks = 0;

  entry_t mq[$];
  entry_t shown = '0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_imm(in_imm),
    .in_src0_sel(in_src0_sel), .in_src1_sel(in_src1_sel), .in_alu_op(in_alu_op),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .exf_we(exf_we), .exf_rd(exf_rd), .exf_data(exf_data),
    .wbf_we(wbf_we), .wbf_rd(wbf_rd), .wbf_data(wbf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op),
    .out_pc(out_pc), .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d;
    if (exf_we && exf_rd == a) return exf_data;
    if (wbf_we && wbf_rd == a) return wbf_data;
    return d;
  endfunction

  function automatic entry_t exp_entry();
    entry_t e;
    e.pc    = in_pc;
    e.op    = in_alu_op;
    e.rd    = in_rd;
    e.rd_we = in_rd_we;
    if (in_src0_sel == 2'd0)      e.src0 = resolve(in_rs1_addr, in_rs1_data);
    else if (in_src0_sel == 2'd1) e.src0 = in_pc;
    else                          e.src0 = 32'd0;
    if (in_src1_sel == 2'd0)      e.src1 = resolve(in_rs2_addr, in_rs2_data);
    else if (in_src1_sel == 2'd1) e.src1 = in_imm;
    else if (in_src1_sel == 2'd2) e.src1 = 32'd4;
    else                          e.src1 = 32'd0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    entry_t got;
    got.pc    = out_pc;
    got.src0  = alu_src0;
    got.src1  = alu_src1;
    got.op    = alu_op;
    got.rd    = out_rd;
    got.rd_we = out_rd_we;
    chk("in_ready", 128'(in_ready), 128'(mq.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    chk("out_entry", 128'(got), 128'(shown));
  endtask

  // Advance one clock with the current inputs, update the model, check at negedge.
  task automatic cycle();
    entry_t qn[$];
    entry_t sn;
    entry_t e;
    int     sz;
    qn = mq;
    sn = shown;
    e  = exp_entry();
    sz = mq.size();
    if (!rstn) begin
      qn = {};
      sn = '0;
    end else if (flush) begin
      qn = {};
    end else begin
      if (sz > 0 && out_ready) void'(qn.pop_front());
      if (in_valid && sz < 2) qn.push_back(e);
    end
    if (qn.size() > 0) sn = qn[0];
    @(posedge clk);
    mq    = qn;
    shown = sn;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
    in_imm = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rd = 0; in_alu_op = 0;
    in_src0_sel = 0; in_src1_sel = 0; in_rd_we = 0;
    exf_we = 0; exf_rd = 0; exf_data = 0; wbf_we = 0; wbf_rd = 0; wbf_data = 0;
  endtask

  initial begin
    logic [31:0] dq[$];
    idle_inputs();
    rstn = 0; out_ready = 0;
    // reset with an offer present: reset must win
    in_valid = 1; in_pc = 32'h77;
    cycle(); cycle();
    chk("rst_alu_op", 128'(alu_op), 128'(5'b00000));
    chk("rst_src0", 128'(alu_src0), 128'(0));
    in_valid = 0;
    rstn = 1;

    // basic rs1 + imm
    in_valid = 1; in_src0_sel = 0; in_src1_sel = 1; in_rs1_addr = 1;
    in_rs1_data = 5; in_imm = 7; in_alu_op = 5'b00000; out_ready = 1;
    cycle();
    chk("basic_src0", 128'(alu_src0), 128'(32'd5));
    chk("basic_src1", 128'(alu_src1), 128'(32'd7));
    in_valid = 0; cycle();

    // forwarding priority and x0
    in_valid = 1; in_rs1_addr = 3; in_rs1_data = 32'h11;
    exf_we = 1; exf_rd = 3; exf_data = 32'hAA; wbf_we = 1; wbf_rd = 3; wbf_data = 32'hBB;
    cycle();
    chk("fwd_exf", 128'(alu_src0), 128'(32'hAA));
    in_rs1_addr = 0; exf_rd = 0; wbf_rd = 0; in_rs1_data = 32'h55;
    cycle();
    chk("fwd_x0", 128'(alu_src0), 128'(32'h55));
    idle_inputs(); cycle();

    // back-pressure: A, B, C with out_ready low
    out_ready = 0; in_valid = 1; in_src0_sel = 1; in_src1_sel = 3;
    in_pc = 32'hA0; cycle();
    in_pc = 32'hB0; cycle();
    in_pc = 32'hC0; cycle(); cycle();
    chk("full_in_ready", 128'(in_ready), 128'(0));
    chk("full_main_pc", 128'(out_pc), 128'(32'hA0));
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_ready) dq.push_back(out_pc);
      if (in_valid && in_ready) begin
        cycle();
        in_valid = 0;
      end else begin
        cycle();
      end
    end
    chk("order_count", 128'(dq.size()), 128'(3));
    if (dq.size() == 3) begin
      chk("order_0", 128'(dq[0]), 128'(32'hA0));
      chk("order_1", 128'(dq[1]), 128'(32'hB0));
      chk("order_2", 128'(dq[2]), 128'(32'hC0));
    end

    // pc and constant 4
    idle_inputs(); in_valid = 1; in_src0_sel = 1; in_src1_sel = 2; in_pc = 32'h1000;
    cycle();
    chk("pc_src0", 128'(alu_src0), 128'(32'h1000));
    chk("four_src1", 128'(alu_src1), 128'(32'd4));
    in_valid = 0; cycle();

    // flush while full
    out_ready = 0; in_valid = 1; in_pc = 32'h1; cycle(); in_pc = 32'h2; cycle();
    flush = 1; in_pc = 32'hDEAD; cycle();
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ready", 128'(in_ready), 128'(1));
    flush = 0; in_valid = 0; out_ready = 1; cycle(); cycle();

    // reset mid-stream with skid full
    out_ready = 0; in_valid = 1; in_src0_sel = 1; in_src1_sel = 1; in_imm = 9;
    in_alu_op = 5'b01011; in_pc = 32'h3; cycle(); in_pc = 32'h4; cycle();
    rstn = 0; cycle();
    chk("mrst_valid", 128'(out_valid), 128'(0));
    chk("mrst_ready", 128'(in_ready), 128'(1));
    chk("mrst_op", 128'(alu_op), 128'(0));
    chk("mrst_srcs", 128'({alu_src0, alu_src1}), 128'(0));
    rstn = 1;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rstn        = ($urandom_range(0, 49) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = $urandom_range(0, 1);
      in_pc       = $urandom; in_rs1_data = $urandom; in_rs2_data = $urandom;
      in_imm      = $urandom; in_alu_op = 5'($urandom_range(0, 31));
      in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
      in_src0_sel = 2'($urandom_range(0, 3)); in_src1_sel = 2'($urandom_range(0, 3));
      in_rd       = 5'($urandom_range(0, 31)); in_rd_we = $urandom_range(0, 1);
      exf_we      = $urandom_range(0, 1); exf_rd = 5'($urandom_range(0, 3)); exf_data = $urandom;
      wbf_we      = $urandom_range(0, 1); wbf_rd = 5'($urandom_range(0, 3)); wbf_data = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
